// File: rtl/xlr_mem_bank.sv
// Banked line memory behind the accelerator's xlr_mem port, plus a host
// load/unload port that yields to accelerator traffic on the same bank.
module xlr_mem_bank #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int LINE_W             = 256,
  parameter int MSEL_W             = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_MEMS*LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
  input  logic [NUM_MEMS*LINE_W-1:0]         xlr_mem_wdata,
  input  logic [NUM_MEMS*(LINE_W/8)-1:0]     xlr_mem_be,
  input  logic [NUM_MEMS-1:0]                xlr_mem_rd,
  input  logic [NUM_MEMS-1:0]                xlr_mem_wr,
  output logic [NUM_MEMS*LINE_W-1:0]         xlr_mem_rdata,
  input  logic                               host_req,
  input  logic                               host_we,
  input  logic [MSEL_W-1:0]                  host_sel,
  input  logic [LOG2_LINES_PER_MEM-1:0]      host_addr,
  input  logic [LINE_W-1:0]                  host_wdata,
  output logic                               host_ready,
  output logic [LINE_W-1:0]                  host_rdata,
  output logic                               host_rvalid
);

  localparam int AW    = LOG2_LINES_PER_MEM;
  localparam int BE_W  = LINE_W / 8;
  localparam int DEPTH = 1 << AW;

  logic [NUM_MEMS-1:0] xlr_busy;
  logic [NUM_MEMS-1:0] host_hit;
  logic                host_rd_acc;
  logic [LINE_W-1:0]   bank_rdata [NUM_MEMS];
  logic [LINE_W-1:0]   host_sel_rdata;

  assign xlr_busy = xlr_mem_rd | xlr_mem_wr;

  // An out-of-range host_sel matches no bank: it stays ready and reads zero.
  always_comb begin
    host_ready     = host_req;
    host_hit       = '0;
    host_sel_rdata = '0;
    for (int unsigned b = 0; b < NUM_MEMS; b++) begin
      if (host_sel == MSEL_W'(b)) begin
        host_ready     = host_req & ~xlr_busy[b];
        host_hit[b]    = host_req & ~xlr_busy[b];
        host_sel_rdata = bank_rdata[b];
      end
    end
  end

  assign host_rd_acc = host_req & host_ready & ~host_we;

  for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
    logic [LINE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     port_addr;
    logic [LINE_W-1:0] wdata;
    logic [BE_W-1:0]   wbe;
    logic              we;
    logic [LINE_W-1:0] rd_q;

    // Single shared address: the host only reaches the bank when the
    // accelerator leaves it idle, so one read/write port suffices.
    assign port_addr = xlr_busy[b] ? xlr_mem_addr[b*AW +: AW] : host_addr;
    assign wdata     = xlr_busy[b] ? xlr_mem_wdata[b*LINE_W +: LINE_W] : host_wdata;
    assign wbe       = xlr_busy[b] ? xlr_mem_be[b*BE_W +: BE_W] : '1;
    assign we        = xlr_mem_wr[b] | (host_hit[b] & host_we);

    assign bank_rdata[b] = mem[port_addr];

    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (we && wbe[i]) mem[port_addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                rd_q <= '0;
      else if (xlr_mem_rd[b]) rd_q <= bank_rdata[b];
    end

    assign xlr_mem_rdata[b*LINE_W +: LINE_W] = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_rd_acc;
      if (host_rd_acc) host_rdata <= host_sel_rdata;
    end
  end

endmodule

// File: tb/tb_xlr_mem_bank.sv
// Scoreboard bench for xlr_mem_bank: stimulus pushes expected responses from
// an array model; a negedge monitor pops and compares them.
module tb_xlr_mem_bank;

  localparam int NM = 2;
  localparam int AW = 8;
  localparam int LW = 256;
  localparam int BW = LW / 8;
  localparam int SW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] xlr_mem_addr;
  logic [NM*LW-1:0] xlr_mem_wdata;
  logic [NM*BW-1:0] xlr_mem_be;
  logic [NM-1:0]    xlr_mem_rd;
  logic [NM-1:0]    xlr_mem_wr;
  logic [NM*LW-1:0] xlr_mem_rdata;
  logic             host_req;
  logic             host_we;
  logic [SW-1:0]    host_sel;
  logic [AW-1:0]    host_addr;
  logic [LW-1:0]    host_wdata;
  logic             host_ready;
  logic [LW-1:0]    host_rdata;
  logic             host_rvalid;

  xlr_mem_bank #(
    .NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW), .LINE_W(LW), .MSEL_W(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .xlr_mem_addr(xlr_mem_addr), .xlr_mem_wdata(xlr_mem_wdata),
    .xlr_mem_be(xlr_mem_be), .xlr_mem_rd(xlr_mem_rd), .xlr_mem_wr(xlr_mem_wr),
    .xlr_mem_rdata(xlr_mem_rdata),
    .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid)
  );

  typedef struct {
    int unsigned bank;
    int unsigned due;
    logic [LW-1:0] d;
  } exp_t;

  exp_t          xq[$];
  exp_t          hq[$];
  logic [LW-1:0] mdl [NM][1<<AW];
  logic [LW-1:0] xlast [NM];
  logic [LW-1:0] hlast;
  int unsigned   cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          h_acc;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: responses become due one edge after issue; otherwise outputs hold.
  always @(negedge clk) begin
    logic exp_v;
    while (xq.size() > 0 && xq[0].due == cyc) begin
      xlast[xq[0].bank] = xq[0].d;
      void'(xq.pop_front());
    end
    for (int b = 0; b < NM; b++)
      check($sformatf("xlr_rdata[%0d]", b), xlr_mem_rdata[b*LW +: LW], xlast[b]);
    exp_v = (hq.size() > 0 && hq[0].due == cyc);
    check("host_rvalid", LW'(host_rvalid), LW'(exp_v));
    if (exp_v) begin
      hlast = hq[0].d;
      void'(hq.pop_front());
    end
    check("host_rdata", host_rdata, hlast);
  end

  // Apply the current inputs for one edge, updating the model and scoreboard.
  task automatic tick();
    logic        exp_ready;
    int unsigned s;
    exp_t        e;
    logic [AW-1:0] a;
    #1;
    s = 32'(host_sel);
    exp_ready = host_req && (s >= NM || !(xlr_mem_rd[s] || xlr_mem_wr[s]));
    check("host_ready", LW'(host_ready), LW'(exp_ready));
    if (!rst) begin
      for (int b = 0; b < NM; b++) begin
        if (xlr_mem_rd[b]) begin
          e.bank = b; e.due = cyc + 1; e.d = mdl[b][xlr_mem_addr[b*AW +: AW]];
          xq.push_back(e);
        end
      end
      if (exp_ready && !host_we) begin
        e.bank = 0; e.due = cyc + 1; e.d = (s < NM) ? mdl[s][host_addr] : '0;
        hq.push_back(e);
      end
      for (int b = 0; b < NM; b++) begin
        if (xlr_mem_wr[b]) begin
          a = xlr_mem_addr[b*AW +: AW];
          for (int i = 0; i < BW; i++)
            if (xlr_mem_be[b*BW + i]) mdl[b][a][8*i +: 8] = xlr_mem_wdata[b*LW + 8*i +: 8];
        end
      end
      if (exp_ready && host_we && s < NM) mdl[s][host_addr] = host_wdata;
    end
    h_acc = exp_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic xset(input int b, input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [LW-1:0] d, input logic [BW-1:0] be);
    xlr_mem_rd[b] = r;
    xlr_mem_wr[b] = w;
    xlr_mem_addr[b*AW +: AW]  = a;
    xlr_mem_wdata[b*LW +: LW] = d;
    xlr_mem_be[b*BW +: BW]    = be;
  endtask

  task automatic xidle(input int b);
    xlr_mem_rd[b] = 1'b0;
    xlr_mem_wr[b] = 1'b0;
  endtask

  task automatic hset(input logic req, input logic we, input logic [SW-1:0] sel,
                      input logic [AW-1:0] a, input logic [LW-1:0] d);
    host_req = req; host_we = we; host_sel = sel; host_addr = a; host_wdata = d;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    xq.delete();
    hq.delete();
    for (int b = 0; b < NM; b++) xlast[b] = '0;
    hlast = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] d;
    rst = 1'b1;
    xlr_mem_addr = '0; xlr_mem_wdata = '0; xlr_mem_be = '0;
    xlr_mem_rd = '0; xlr_mem_wr = '0;
    hset(1'b0, 1'b0, '0, '0, '0);
    hlast = '0;
    for (int b = 0; b < NM; b++) xlast[b] = '0;

    // Reset held with no requests
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Preload every line through the host port
    for (int b = 0; b < NM; b++)
      for (int a = 0; a < (1<<AW); a++) begin
        hset(1'b1, 1'b1, SW'(b), AW'(a), rand_line());
        tick();
      end
    hset(1'b0, 1'b0, '0, '0, '0);

    // Host write then read back bank0 line 0x05
    hset(1'b1, 1'b1, 1'b0, 8'h05, {BW{8'hA5}}); tick();
    hset(1'b1, 1'b0, 1'b0, 8'h05, '0); tick();
    hset(1'b0, 1'b0, '0, '0, '0); tick(); tick();

    // Byte-enabled accelerator write over a zeroed line, then be=0 write
    hset(1'b1, 1'b1, 1'b1, 8'hFF, '0); tick();
    hset(1'b0, 1'b0, '0, '0, '0);
    d = rand_line(); d[31:0] = 32'h1122_3344;
    xset(1, 1'b0, 1'b1, 8'hFF, d, 32'h0000_000F); tick();
    xset(1, 1'b1, 1'b0, 8'hFF, '0, '0); tick();
    xset(1, 1'b0, 1'b1, 8'hFF, rand_line(), '0); tick();
    xset(1, 1'b1, 1'b0, 8'hFF, '0, '0); tick();
    xidle(1); tick(); tick();

    // Read-before-write on bank0 line 0x10
    xset(0, 1'b0, 1'b1, 8'h10, LW'(16'hDEAD), '1); tick();
    xset(0, 1'b1, 1'b1, 8'h10, LW'(16'hBEEF), '1); tick();
    xset(0, 1'b1, 1'b0, 8'h10, '0, '0); tick();
    xidle(0); tick();

    // Host stalls behind three accelerator reads on bank0
    hset(1'b1, 1'b0, 1'b0, 8'h05, '0);
    xset(0, 1'b1, 1'b0, 8'h10, '0, '0);
    repeat (3) tick();
    xidle(0); tick();
    hset(1'b0, 1'b0, '0, '0, '0); tick();

    // Host on bank1 proceeds alongside accelerator on bank0
    xset(0, 1'b1, 1'b0, 8'h10, '0, '0);
    hset(1'b1, 1'b0, 1'b1, 8'hFF, '0); tick();
    xidle(0); hset(1'b0, 1'b0, '0, '0, '0); tick(); tick();

    // Reset right after an accepted host read drops the response
    hset(1'b1, 1'b0, 1'b0, 8'h05, '0); tick();
    hset(1'b0, 1'b0, '0, '0, '0);
    do_reset(2);
    tick();
    hset(1'b1, 1'b0, 1'b0, 8'h05, '0); tick();
    hset(1'b0, 1'b0, '0, '0, '0); tick(); tick();

    // Randomized mixed traffic; host holds its request until accepted
    repeat (3000) begin
      for (int b = 0; b < NM; b++) begin
        if ($urandom_range(0, 2) == 0)
          xset(b, 1'($urandom), 1'($urandom), AW'($urandom), rand_line(), BW'($urandom));
        else
          xidle(b);
      end
      if (!host_req && $urandom_range(0, 1) == 1)
        hset(1'b1, 1'($urandom), SW'($urandom), AW'($urandom), rand_line());
      tick();
      if (h_acc) host_req = 1'b0;
    end

    for (int b = 0; b < NM; b++) xidle(b);
    hset(1'b0, 1'b0, '0, '0, '0);
    repeat (4) tick();
    check("drain", LW'(xq.size() + hq.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
